// File: rtl/alu_result_tx.sv
// alu_result_tx: converts one binary result word per input beat into an ASCII
// hex byte stream (optionally zero-suppressed, "ERR" on error, CR/LF appended)
// on an 8-bit AXI-stream master. One message in flight at a time.
module alu_result_tx #(
    parameter int unsigned RESULT_WIDTH   = 32,
    parameter bit          INCLUDE_CRLF   = 1'b1,
    parameter bit          UPPERCASE      = 1'b1,
    parameter bit          SUPPRESS_ZEROS = 1'b1
) (
    input  logic                    aclk_i,
    input  logic                    arst_ni,
    input  logic [RESULT_WIDTH-1:0] s_axis_tdata_i,
    input  logic                    s_axis_tuser_i,
    input  logic                    s_axis_tvalid_i,
    output logic                    s_axis_tready_o,
    output logic [7:0]              m_axis_tdata_o,
    output logic                    m_axis_tvalid_o,
    output logic                    m_axis_tlast_o,
    input  logic                    m_axis_tready_i
);

    localparam int unsigned N    = RESULT_WIDTH / 4;
    // index register is shared between nibble position and "ERR" character position
    localparam int unsigned IDXW = ($clog2(N) > 2) ? $clog2(N) : 2;
    localparam logic [IDXW-1:0] TOP_IDX  = IDXW'(N - 1);
    localparam logic [IDXW-1:0] ERR_LAST = IDXW'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIGIT,
        S_ERR,
        S_CR,
        S_LF
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [RESULT_WIDTH-1:0] data_q, data_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    s_ready_q, s_ready_d;
    logic [IDXW-1:0]         start_idx;
    logic                    accept;
    logic                    fire;
    logic [3:0]              nib;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] base;
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        base = UPPERCASE ? 8'h41 : 8'h61;
        return base + {4'h0, n} - 8'd10;
    endfunction

    assign accept = s_ready_q & s_axis_tvalid_i;
    assign fire   = tvalid_q & m_axis_tready_i;

    // First digit position for the incoming word: highest nonzero nibble, or the top nibble
    always_comb begin
        start_idx = SUPPRESS_ZEROS ? '0 : TOP_IDX;
        if (SUPPRESS_ZEROS) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (s_axis_tdata_i[4*i +: 4] != 4'h0) begin
                    start_idx = IDXW'(i);
                end
            end
        end
    end

    // State register plus registered output stage
    always_ff @(posedge aclk_i) begin
        if (!arst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            s_ready_q <= s_ready_d;
        end
    end

    // Next-state: capture on accept, advance one character per output handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d = s_axis_tdata_i;
                    if (s_axis_tuser_i) begin
                        state_d = S_ERR;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DIGIT;
                        idx_d   = start_idx;
                    end
                end
            end
            S_DIGIT: begin
                if (fire) begin
                    if (idx_q == '0) begin
                        state_d = INCLUDE_CRLF ? S_CR : S_IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (fire) begin
                    if (idx_q == ERR_LAST) begin
                        state_d = INCLUDE_CRLF ? S_CR : S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_CR: begin
                if (fire) begin
                    state_d = S_LF;
                end
            end
            S_LF: begin
                if (fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every m_axis output is a plain register;
    // a stall keeps state_d/idx_d unchanged, so the registered byte holds.
    always_comb begin
        nib       = 4'(data_d >> {idx_d, 2'b00});
        tvalid_d  = (state_d != S_IDLE);
        s_ready_d = (state_d == S_IDLE);
        tdata_d   = 8'h00;
        unique case (state_d)
            S_DIGIT: tdata_d = hex_ascii(nib);
            S_ERR:   tdata_d = (idx_d == '0) ? 8'h45 : 8'h52;
            S_CR:    tdata_d = 8'h0D;
            S_LF:    tdata_d = 8'h0A;
            default: tdata_d = 8'h00;
        endcase
        tlast_d = (state_d == S_LF) ||
                  (!INCLUDE_CRLF && (((state_d == S_DIGIT) && (idx_d == '0)) ||
                                     ((state_d == S_ERR) && (idx_d == ERR_LAST))));
    end

    assign s_axis_tready_o = s_ready_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tlast_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx: two instances (default parameters and
// no-suppression/lowercase/no-CRLF), table vectors, hand sequences, random messages.
module tb_alu_result_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic [31:0] s_tdata;
    logic        s_tuser, s_tvalid, m_tready;

    logic        r1_s_ready, r1_tvalid, r1_tlast;
    logic [7:0]  r1_tdata;
    logic        r2_s_ready, r2_tvalid, r2_tlast;
    logic [7:0]  r2_tdata;

    logic        sel;
    logic        s_ready, tvalid, tlast;
    logic [7:0]  tdata;

    alu_result_tx dut1 (
        .aclk_i(clk), .arst_ni(arst_n),
        .s_axis_tdata_i(s_tdata), .s_axis_tuser_i(s_tuser),
        .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(r1_s_ready),
        .m_axis_tdata_o(r1_tdata), .m_axis_tvalid_o(r1_tvalid),
        .m_axis_tlast_o(r1_tlast), .m_axis_tready_i(m_tready)
    );

    alu_result_tx #(
        .RESULT_WIDTH(32), .INCLUDE_CRLF(1'b0), .UPPERCASE(1'b0), .SUPPRESS_ZEROS(1'b0)
    ) dut2 (
        .aclk_i(clk), .arst_ni(arst_n),
        .s_axis_tdata_i(s_tdata), .s_axis_tuser_i(s_tuser),
        .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(r2_s_ready),
        .m_axis_tdata_o(r2_tdata), .m_axis_tvalid_o(r2_tvalid),
        .m_axis_tlast_o(r2_tlast), .m_axis_tready_i(m_tready)
    );

    always_comb begin
        s_ready = sel ? r2_s_ready : r1_s_ready;
        tvalid  = sel ? r2_tvalid  : r1_tvalid;
        tlast   = sel ? r2_tlast   : r1_tlast;
        tdata   = sel ? r2_tdata   : r1_tdata;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] v;
        bit          err;
        bit          cfg;
        string       digits;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void add(input logic [31:0] v, input bit err, input bit cfg, input string d);
        vec_t e;
        e.v = v; e.err = err; e.cfg = cfg; e.digits = d;
        tbl.push_back(e);
    endfunction

    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    // Reference: text formatting of the value, then optional line ending
    function automatic void model(input logic [31:0] v, input bit err);
        string s;
        bit    dflt = (sel == 1'b0);
        if (err) s = "ERR";
        else begin
            s = dflt ? $sformatf("%0h", v) : $sformatf("%08h", v);
            if (dflt) s = s.toupper();
        end
        exp_q.delete();
        push_str(s);
        if (dflt) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        arst_n   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tvalid1", r1_tvalid, 0);  check("rst_tdata1", r1_tdata, 0);
        check("rst_tlast1", r1_tlast, 0);    check("rst_sready1", r1_s_ready, 0);
        check("rst_tvalid2", r2_tvalid, 0);  check("rst_tdata2", r2_tdata, 0);
        check("rst_sready2", r2_s_ready, 0);
        arst_n = 1'b1;
        @(negedge clk);
        check("rel_sready1", r1_s_ready, 1);
        check("rel_sready2", r2_s_ready, 1);
    endtask

    // Called at a negedge; sends one word and consumes the message against exp_q.
    // hold=1 keeps s_tvalid high with junk data while busy, then presents nxt.
    task automatic run_msg(input logic [31:0] v, input bit err, input bit rnd_ready,
                           input bit hold, input logic [31:0] nxt);
        int n;
        bit done, rdy_seen, pstall;
        logic [7:0] pd, eb;
        logic pl;
        s_tdata = v; s_tuser = err; s_tvalid = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", s_ready, 1);
        @(negedge clk);
        if (hold) begin s_tdata = $urandom; s_tuser = 1'($urandom); end
        else begin s_tvalid = 1'b0; s_tdata = $urandom; s_tuser = 1'($urandom); end
        check("first_latency", tvalid, 1);
        done = 0; rdy_seen = 0; pstall = 0; pd = '0; pl = 0; n = 0;
        while (!done && n < 300) begin
            if (pstall) begin
                check("stall_tdata", tdata, pd);
                check("stall_tlast", tlast, pl);
                check("stall_tvalid", tvalid, 1);
            end
            if (s_ready) rdy_seen = 1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) s_tdata = $urandom;
            if (tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", tdata, 32'hFFFF_FFFF);
                    done = 1;
                end else begin
                    eb = exp_q.pop_front();
                    check("tdata", tdata, eb);
                    check("tlast", tlast, exp_q.size() == 0);
                    if (tlast || exp_q.size() == 0) done = 1;
                end
            end
            if (done && hold) begin s_tdata = nxt; s_tuser = 1'b0; end
            pstall = tvalid && !m_tready;
            pd = tdata; pl = tlast;
            @(negedge clk);
            n++;
        end
        check("msg_complete", done, 1);
        check("sready_busy", rdy_seen, 0);
        check("bubble_tvalid", tvalid, 0);
        check("bubble_sready", s_ready, 1);
        m_tready = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        sel = 1'b0;

        add(32'h0000002A, 0, 0, "2A");
        add(32'h00000000, 0, 0, "0");
        add(32'hCAFEF00D, 1, 0, "ERR");
        add(32'hFFFFFFFF, 0, 0, "FFFFFFFF");
        add(32'h00000010, 0, 0, "10");
        add(32'h12345678, 0, 0, "12345678");
        add(32'hDEADBEEF, 0, 1, "deadbeef");
        add(32'h0000000F, 0, 1, "0000000f");
        add(32'h00000000, 0, 1, "00000000");
        add(32'h00000005, 1, 1, "ERR");

        do_reset();

        foreach (tbl[k]) begin
            if (tbl[k].cfg != sel) begin
                do_reset();
                sel = tbl[k].cfg;
            end
            exp_q.delete();
            push_str(tbl[k].digits);
            if (tbl[k].cfg == 1'b0) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
            run_msg(tbl[k].v, tbl[k].err, tbl[k].v == 32'h12345678, 1'b0, '0);
        end

        // Reset in the middle of a message
        do_reset();
        sel = 1'b0;
        s_tdata = 32'h0000ABCD; s_tuser = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        check("mid_b1", tdata, 8'h41);
        @(negedge clk);
        check("mid_b2", tdata, 8'h42);
        @(negedge clk);
        check("mid_b3", tdata, 8'h43);
        arst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_tdata", tdata, 0);
        check("mid_rst_tlast", tlast, 0);
        check("mid_rst_sready", s_ready, 0);
        arst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_sready", s_ready, 1);
        check("mid_rel_tvalid", tvalid, 0);
        model(32'h1, 0);
        run_msg(32'h1, 0, 0, 0, '0);

        // Back-to-back with s_tvalid held high
        model(32'h1, 0); run_msg(32'h1, 0, 0, 1, 32'h2);
        model(32'h2, 0); run_msg(32'h2, 0, 0, 1, 32'h3);
        model(32'h3, 0); run_msg(32'h3, 0, 0, 0, '0);

        // Random messages, default configuration
        for (int k = 0; k < 30; k++) begin
            logic [31:0] v;
            bit e;
            v = $urandom >> $urandom_range(0, 31);
            e = ($urandom_range(0, 7) == 0);
            model(v, e);
            run_msg(v, e, 1'b1, 1'($urandom_range(0, 1)), v + 1);
        end

        // Random messages, alternate configuration
        do_reset();
        sel = 1'b1;
        for (int k = 0; k < 15; k++) begin
            logic [31:0] v;
            bit e;
            v = $urandom >> $urandom_range(0, 31);
            e = ($urandom_range(0, 7) == 0);
            model(v, e);
            run_msg(v, e, 1'b1, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
